jesd204_tpl_dac_framer: RTL and testbench
=========================================

# jesd204_tpl_dac_framer

Transmit-side JESD204 transport layer core: takes per-channel DAC samples from the DMA (or internal test sources), formats them, and packs them into per-lane link beats for the JESD204 TX link layer. It is the mirror of the ADC deframer and sits between the DAC DMA/channel logic and the JESD204 TX link in the `link_clk` domain. The block includes a two-stage stall-able pipeline, per-channel ramp and PN7 generators, and an underflow counter.

## Interface
- `NUM_LANES`, 2, number of JESD lanes (L)
- `NUM_CHANNELS`, 2, converters (M)
- `SAMPLES_PER_FRAME`, 1, samples per converter per frame (S)
- `CONVERTER_RESOLUTION`, 16, N; must be ≤ `BITS_PER_SAMPLE`
- `BITS_PER_SAMPLE`, 16, NP; fixed at 16
- `OCTETS_PER_BEAT`, 4, octets per lane per clock
- `TWOS_COMPLEMENT`, 1, 1 = two's complement output, 0 = offset binary
- Derived: DPW = OCTETS_PER_BEAT\*8\*NUM_LANES/NUM_CHANNELS/16 samples per channel per beat (2 at defaults)
- `link_clk` in 1: single clock for the whole block. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high
- `enable` in NUM_CHANNELS: per-channel DMA enable
- `data_sel` in 2\*NUM_CHANNELS: per-channel source; 0 = DMA, 1 = zero, 2 = PN7, 3 = ramp
- `dac_valid` out NUM_CHANNELS: DMA read strobe, one per channel
- `dac_ddata` in 16\*DPW\*NUM_CHANNELS: DMA samples; channel c, sample s at bits [16\*(c\*DPW+s) +: 16]; s=0 is oldest
- `dac_dunf` in 1: DMA underflow, valid when any `dac_valid` is high
- `dunf_count` out 16: saturating count of underflowed beats
- `link_valid` out 1
- `link_ready` in 1
- `link_data` out 32\*NUM_LANES: lane l at bits [32\*l +: 32]; octet 0 (first transmitted) in bits [7:0]

## Operation
- `adv = link_ready | ~link_valid`. All state advances only when `adv` = 1.
- **Stage 1 (source select):**
  - `dac_valid[c] = adv & enable[c] & (data_sel[c]==0)`. `dac_ddata` is sampled in the same cycle.
  - DMA source: when `dac_dunf` = 1, the channel samples are replaced with 0.
  - Ramp: a per-channel 16-bit counter R. Emits R, R+1, …, R+DPW-1, then sets R += DPW (wraps mod 2^16). It advances only on `adv` cycles while selected.
  - PN7: x^7+x^6+1, seeded 7'h7F at reset. It emits 16\*DPW bits per beat, with the first sequence bit in MSB of sample 0.
  - `data_sel` = 1 outputs zero.
  - A disabled channel with `data_sel` = 0 outputs zero and holds `dac_valid` low.
- **Format:**
  - Keep the top N bits; clear the low 16−N bits.
  - If `TWOS_COMPLEMENT` = 0, invert bit 15.
- **Stage 2 (framing):** for each frame, concatenate samples channel 0 first (within a channel, sample order 0..S-1), MSB first. This gives a bit string of M\*S\*16 bits. Split it into L chunks of F = M\*S\*2/L octets. Lane 0 takes the first chunk, and the first octet in the chunk is the first transmitted. Frames within a beat are placed in increasing octet order.
- **`dunf_count`:** increments on each `adv` cycle with `dac_dunf` = 1 and any `dac_valid` high. It saturates at 16'hFFFF.

## Timing
- **Reset values:**
  - `link_valid` 0, `link_data` 0, `dac_valid` 0, `dunf_count` 0.
  - Ramp counters 0, PN state 7'h7F.
  - Both stages are marked empty.
- **Fill after reset:**
  - Stage 1 loads on the first cycle after `reset` deasserts.
  - Stage 2 loads on the second cycle.
  - `link_valid` = 1 from the second cycle on, then stays 1 until reset.
- **Latency:** DMA sample accepted in cycle T appears on `link_data` in cycle T+2 if there are no stalls.
- **Stall:** while `link_valid & ~link_ready`:
  - `link_data` is held stable.
  - `dac_valid` = 0.
  - Generators and stage 1 freeze.
  - No beat is lost or duplicated.
- **Changes during operation:**
  - A `data_sel` change takes effect on the next `adv` beat.
  - Reset asserted mid-stream clears all state on the next edge regardless of `link_ready`.

## Configuration
- `JESD204_TPL_DAC_PN_EN`:
  - Defined: PN7 generators are compiled in.
  - Undefined: no PN logic; `data_sel` = 2 outputs zero, like `data_sel` = 1.

## Test plan
- Defaults, `link_ready`=1, ch0 DMA `dac_ddata` ch0={0x1234,0x5678}, ch1={0x9ABC,0xDEF0} → 2 cycles later lane0 = 0x78563412, lane1 = 0xF0DEBC9A (octet 0 = MSB of sample 0).
- Ramp on both channels → consecutive beats show ch samples {0,1},{2,3}. Preload near wrap: {0xFFFE,0xFFFF} is followed by {0x0000,0x0001}.
- Hold `link_ready` low 5 cycles mid-stream → `link_data` constant, `dac_valid`=0 throughout. The next beats resume with no gap or repeat.
- `dac_dunf`=1 for 3 accepted beats → those beats output 0x0000 samples and `dunf_count`=3. Forcing 70000 underflows → `dunf_count`=0xFFFF.
- `TWOS_COMPLEMENT`=0, N=14, sample 0x8003 → emitted 0x0000. Sample 0x7FFF → 0xFFFC.
- PN7 with `JESD204_TPL_DAC_PN_EN` defined → first ch0 sample after reset = 0xFE04. Macro undefined → 0x0000.

Source files
------------

// File: rtl/jesd204_tpl_dac_framer.sv
// jesd204_tpl_dac_framer
//
// Transmit-side JESD204 transport layer. It takes per-channel samples from
// the DAC DMA or from an internal source (zero, ramp, PN7). Each sample is
// formatted to the converter resolution and output coding. The samples are
// then packed into per-lane link beats for the TX link layer.
//
// The datapath is a two-stage pipeline:
//   stage 1 : source select + format, registered into s1_data
//   stage 2 : frame packing, registered into link_data
// Both stages advance together whenever the link can accept a beat, or when
// the output register is still empty.
//
// Optional feature macro: JESD204_TPL_DAC_PN_EN
//   defined   : per-channel PN7 generators are built, and data_sel = 2 selects them
//   undefined : no PN logic, and data_sel = 2 outputs zero
//
// Ports:
//   link_clk    single clock for the whole block
//   reset       synchronous, active-high
//   enable      per-channel DMA enable
//   data_sel    per-channel source, 2 bits each: 0 DMA, 1 zero, 2 PN7, 3 ramp
//   dac_valid   per-channel DMA read strobe
//   dac_ddata   DMA samples; channel c, sample s at [16*(c*DPW+s) +: 16]
//   dac_dunf    DMA underflow flag, qualified by any dac_valid
//   dunf_count  saturating count of underflowed beats
//   link_valid  output beat valid
//   link_ready  link layer accepts the beat
//   link_data   lane l at [8*OCTETS_PER_BEAT*l +: 8*OCTETS_PER_BEAT], octet 0 in the low byte

module jesd204_tpl_dac_framer #(
    parameter int NUM_LANES            = 2,
    parameter int NUM_CHANNELS         = 2,
    parameter int SAMPLES_PER_FRAME    = 1,
    parameter int CONVERTER_RESOLUTION = 16,
    parameter int BITS_PER_SAMPLE      = 16,
    parameter int OCTETS_PER_BEAT      = 4,
    parameter int TWOS_COMPLEMENT      = 1,
    localparam int DPW = OCTETS_PER_BEAT * 8 * NUM_LANES / NUM_CHANNELS / 16
) (
    input  logic                               link_clk,
    input  logic                               reset,
    input  logic [NUM_CHANNELS-1:0]            enable,
    input  logic [2*NUM_CHANNELS-1:0]          data_sel,
    output logic [NUM_CHANNELS-1:0]            dac_valid,
    input  logic [16*DPW*NUM_CHANNELS-1:0]     dac_ddata,
    input  logic                               dac_dunf,
    output logic [15:0]                        dunf_count,
    output logic                               link_valid,
    input  logic                               link_ready,
    output logic [8*OCTETS_PER_BEAT*NUM_LANES-1:0] link_data
);

    localparam int CH_W   = 16 * DPW;
    localparam int DATA_W = CH_W * NUM_CHANNELS;
    localparam int LANE_W = 8 * OCTETS_PER_BEAT;
    // Octets per lane per frame, and frames carried in one beat
    localparam int F      = NUM_CHANNELS * SAMPLES_PER_FRAME * 2 / NUM_LANES;
    localparam int FPB    = OCTETS_PER_BEAT / F;
    localparam logic [15:0] FMT_MASK = 16'hFFFF << (BITS_PER_SAMPLE - CONVERTER_RESOLUTION);

    logic                               adv;
    logic                               s1_valid;
    logic [DATA_W-1:0]                  s1_data;
    logic [DATA_W-1:0]                  src_data;
    logic [DATA_W-1:0]                  fmt_data;
    logic [LANE_W*NUM_LANES-1:0]        frame_data;
    logic [NUM_CHANNELS-1:0][15:0]      ramp_q;
    logic [NUM_CHANNELS-1:0][15:0]      ramp_next;
    logic [1:0]                         sel;
`ifdef JESD204_TPL_DAC_PN_EN
    logic [NUM_CHANNELS-1:0][6:0]       pn_q;
    logic [NUM_CHANNELS-1:0][6:0]       pn_next;
    logic [6:0]                         pn_tmp;
    logic [CH_W-1:0]                    pn_bits;
`endif

    // The whole pipeline moves when the output slot is free or being taken
    assign adv = link_ready | ~link_valid;

    // Keep the top N bits. Offset binary is two's complement with the MSB flipped.
    function automatic logic [15:0] fmt_sample(input logic [15:0] x);
        logic [15:0] y;
        y = x & FMT_MASK;
        if (TWOS_COMPLEMENT == 0) begin
            y[15] = ~y[15];
        end
        return y;
    endfunction

    // Stage 1 source select, and the next state of the generators.
    // dac_valid is gated by reset so that the DMA sees no reads while the
    // pipeline is being cleared, even though adv is high then.
    always_comb begin
        dac_valid = '0;
        src_data  = '0;
        ramp_next = ramp_q;
        sel       = 2'd0;
`ifdef JESD204_TPL_DAC_PN_EN
        pn_next   = pn_q;
        pn_tmp    = 7'h00;
        pn_bits   = '0;
`endif
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            sel = data_sel[2*c +: 2];
            case (sel)
                2'd0: begin
                    if (enable[c]) begin
                        dac_valid[c] = adv & ~reset;
                        if (!dac_dunf) begin
                            src_data[CH_W*c +: CH_W] = dac_ddata[CH_W*c +: CH_W];
                        end
                    end
                end
                2'd3: begin
                    for (int s = 0; s < DPW; s++) begin
                        src_data[16*(c*DPW+s) +: 16] = ramp_q[c] + 16'(s);
                    end
                    ramp_next[c] = ramp_q[c] + 16'(DPW);
                end
`ifdef JESD204_TPL_DAC_PN_EN
                // State bit 6 is the next sequence bit to send. The first bit
                // sent in a beat goes into the MSB of sample 0.
                2'd2: begin
                    pn_tmp = pn_q[c];
                    for (int b = 0; b < CH_W; b++) begin
                        pn_bits[16*(b/16) + 15 - (b%16)] = pn_tmp[6];
                        pn_tmp = {pn_tmp[5:0], pn_tmp[6] ^ pn_tmp[5]};
                    end
                    src_data[CH_W*c +: CH_W] = pn_bits;
                    pn_next[c] = pn_tmp;
                end
`endif
                default: ;
            endcase
        end
    end

    // Format every sample on its way into stage 1
    always_comb begin
        fmt_data = '0;
        for (int i = 0; i < DATA_W/16; i++) begin
            fmt_data[16*i +: 16] = fmt_sample(src_data[16*i +: 16]);
        end
    end

    // Ramp and PN generators step only on beats that are actually taken
    always_ff @(posedge link_clk) begin
        if (reset) begin
            ramp_q <= '0;
`ifdef JESD204_TPL_DAC_PN_EN
            pn_q   <= {NUM_CHANNELS{7'h7F}};
`endif
        end else if (adv) begin
            ramp_q <= ramp_next;
`ifdef JESD204_TPL_DAC_PN_EN
            pn_q   <= pn_next;
`endif
        end
    end

    // Stage 1 register. Once it is filled it stays full until reset.
    always_ff @(posedge link_clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (adv) begin
            s1_valid <= 1'b1;
            s1_data  <= fmt_data;
        end
    end

    // Frame packing is pure wiring. Frame f uses sample f*S.. of each channel.
    // Its octet string (channel 0 first, MSB first) is cut into F-octet chunks,
    // one chunk per lane, and frames are laid out in increasing octet order.
    for (genvar f = 0; f < FPB; f++) begin : g_frame
        for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
            for (genvar j = 0; j < F; j++) begin : g_oct
                localparam int OCT      = l*F + j;
                localparam int CH       = (OCT/2) / SAMPLES_PER_FRAME;
                localparam int SMP      = f*SAMPLES_PER_FRAME + (OCT/2) % SAMPLES_PER_FRAME;
                localparam int BYTE_LSB = 16*(CH*DPW + SMP) + (((OCT % 2) == 0) ? 8 : 0);
                assign frame_data[LANE_W*l + 8*(f*F + j) +: 8] = s1_data[BYTE_LSB +: 8];
            end
        end
    end

    // Stage 2 / output register
    always_ff @(posedge link_clk) begin
        if (reset) begin
            link_valid <= 1'b0;
            link_data  <= '0;
        end else if (adv && s1_valid) begin
            link_valid <= 1'b1;
            link_data  <= frame_data;
        end
    end

    // Underflow counter. It counts only beats where the DMA was really read.
    always_ff @(posedge link_clk) begin
        if (reset) begin
            dunf_count <= 16'h0000;
        end else if (dac_dunf && (|dac_valid) && (dunf_count != 16'hFFFF)) begin
            dunf_count <= dunf_count + 16'h0001;
        end
    end

endmodule

// File: tb/tb_jesd204_tpl_dac_framer.sv
// tb_jesd204_tpl_dac_framer
//
// Directed bench for jesd204_tpl_dac_framer at default parameters (L=2, M=2,
// S=1, 4 octets per beat, DPW=2). A second instance uses N=14 with offset
// binary output to exercise the format step. Expected lane words are
// hand-computed. lane_word() builds a lane from two samples of one channel:
// octet 0 is the MSB of sample 0.

module tb_jesd204_tpl_dac_framer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  enable;
    logic [3:0]  data_sel;
    logic [1:0]  dac_valid;
    logic [63:0] dac_ddata;
    logic        dac_dunf;
    logic [15:0] dunf_count;
    logic        link_valid;
    logic        link_ready;
    logic [63:0] link_data;

    logic [1:0]  f_enable;
    logic [3:0]  f_data_sel;
    logic [1:0]  f_dac_valid;
    logic [63:0] f_dac_ddata;
    logic        f_dac_dunf;
    logic [15:0] f_dunf_count;
    logic        f_link_valid;
    logic        f_link_ready;
    logic [63:0] f_link_data;

    int checks   = 0;
    int failures = 0;

    logic pn_seq [0:127];

    typedef struct {
        logic [1:0]  en;
        logic [3:0]  sel;
        logic [63:0] data;
        logic        dunf;
        logic [1:0]  exp_valid;
        logic [31:0] exp_l0;
        logic [31:0] exp_l1;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    jesd204_tpl_dac_framer dut (
        .link_clk   (clk),
        .reset      (reset),
        .enable     (enable),
        .data_sel   (data_sel),
        .dac_valid  (dac_valid),
        .dac_ddata  (dac_ddata),
        .dac_dunf   (dac_dunf),
        .dunf_count (dunf_count),
        .link_valid (link_valid),
        .link_ready (link_ready),
        .link_data  (link_data)
    );

    jesd204_tpl_dac_framer #(
        .CONVERTER_RESOLUTION (14),
        .TWOS_COMPLEMENT      (0)
    ) u_fmt (
        .link_clk   (clk),
        .reset      (reset),
        .enable     (f_enable),
        .data_sel   (f_data_sel),
        .dac_valid  (f_dac_valid),
        .dac_ddata  (f_dac_ddata),
        .dac_dunf   (f_dac_dunf),
        .dunf_count (f_dunf_count),
        .link_valid (f_link_valid),
        .link_ready (f_link_ready),
        .link_data  (f_link_data)
    );

    function automatic logic [31:0] lane_word(input logic [15:0] s0, input logic [15:0] s1);
        return {s1[7:0], s1[15:8], s0[7:0], s0[15:8]};
    endfunction

    function automatic logic [63:0] ddata(input logic [15:0] a0, input logic [15:0] a1,
                                          input logic [15:0] b0, input logic [15:0] b1);
        return {b1, b0, a1, a0};
    endfunction

    function automatic logic [15:0] pn_sample(input int j);
        logic [15:0] r;
        for (int b = 0; b < 16; b++) begin
            r[15-b] = pn_seq[16*j + b];
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] en, input logic [3:0] sel, input logic [63:0] data,
                                 input logic dunf, input logic ready);
        enable     = en;
        data_sel   = sel;
        dac_ddata  = data;
        dac_dunf   = dunf;
        link_ready = ready;
    endtask

    // Channel 0 runs the ramp and channel 1 reads a constant DMA pattern.
    // Reset is released at the current negedge (n = 0). The expected beat
    // index moves on only after a cycle that shows a valid beat with ready
    // high, so a stall must hold the data, with no beat lost or repeated.
    task automatic runRampCheck(input int n_cycles, input int stall_at, input int stall_len, input string tag);
        int   k;
        logic ready;
        k = 0;
        for (int n = 0; n < n_cycles; n++) begin
            if (n > 0) @(negedge clk);
            if (n >= 2) begin
                checkOutput({tag, "_valid"}, 64'(link_valid), 64'd1);
                checkOutput({tag, "_lane0"}, 64'(link_data[31:0]), 64'(lane_word(16'(2*k), 16'(2*k+1))));
                checkOutput({tag, "_lane1"}, 64'(link_data[63:32]), 64'h22221111);
            end else begin
                checkOutput({tag, "_fill_valid"}, 64'(link_valid), 64'd0);
            end
            ready = !(n >= stall_at && n < stall_at + stall_len);
            reset = 1'b0;
            applyStimulus(2'b11, 4'b0011, ddata(16'h0, 16'h0, 16'h1111, 16'h2222), 1'b0, ready);
            #1;
            checkOutput({tag, "_dac_valid"}, 64'(dac_valid), 64'({(ready || n < 2), 1'b0}));
            if (n >= 2 && ready) k++;
        end
    endtask

    initial begin
        int bad;
        int k;

        for (int i = 0; i < 7; i++) pn_seq[i] = 1'b1;
        for (int i = 7; i < 128; i++) pn_seq[i] = pn_seq[i-6] ^ pn_seq[i-7];

        vecs[0] = '{2'b11, 4'b0000, ddata(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0), 1'b0, 2'b11, 32'h78563412, 32'hF0DEBC9A};
        vecs[1] = '{2'b01, 4'b0000, ddata(16'h0102, 16'h0304, 16'h5555, 16'h6666), 1'b0, 2'b01, 32'h04030201, 32'h00000000};
        vecs[2] = '{2'b11, 4'b0001, ddata(16'h1111, 16'h2222, 16'hCAFE, 16'hBEEF), 1'b0, 2'b10, 32'h00000000, 32'hEFBEFECA};
        vecs[3] = '{2'b11, 4'b0000, ddata(16'hABCD, 16'hABCD, 16'hABCD, 16'hABCD), 1'b1, 2'b11, 32'h00000000, 32'h00000000};
        vecs[4] = '{2'b11, 4'b0000, ddata(16'h7777, 16'h8888, 16'h9999, 16'hAAAA), 1'b1, 2'b11, 32'h00000000, 32'h00000000};
        vecs[5] = '{2'b10, 4'b0000, ddata(16'h4321, 16'h4321, 16'h4321, 16'h4321), 1'b1, 2'b10, 32'h00000000, 32'h00000000};
        vecs[6] = '{2'b11, 4'b0000, ddata(16'h8001, 16'h7FFE, 16'hFFFF, 16'h0000), 1'b0, 2'b11, 32'hFE7F0180, 32'h0000FFFF};
        vecs[7] = '{2'b00, 4'b0000, ddata(16'h1357, 16'h2468, 16'h1357, 16'h2468), 1'b1, 2'b00, 32'h00000000, 32'h00000000};
        vecs[8] = '{2'b11, 4'b0101, ddata(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 1'b1, 2'b00, 32'h00000000, 32'h00000000};

        // Format instance: ch0 DMA {0x8003, 0x7FFF}, ch1 zero source
        f_enable     = 2'b01;
        f_data_sel   = 4'b0100;
        f_dac_ddata  = ddata(16'h8003, 16'h7FFF, 16'h0000, 16'h0000);
        f_dac_dunf   = 1'b0;
        f_link_ready = 1'b1;

        // Reset state, with the DMA enabled to show that reads are blocked
        reset = 1'b1;
        applyStimulus(2'b11, 4'b0000, 64'h0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("reset_link_valid", 64'(link_valid), 64'd0);
        checkOutput("reset_link_data", link_data, 64'd0);
        checkOutput("reset_dac_valid", 64'(dac_valid), 64'd0);
        checkOutput("reset_dunf_count", 64'(dunf_count), 64'd0);

        // Table vectors streamed back to back, compared two cycles later
        for (int n = 0; n < NV + 2; n++) begin
            if (n > 0) @(negedge clk);
            if (n == 1) checkOutput("fill_valid_c1", 64'(link_valid), 64'd0);
            if (n >= 2) begin
                checkOutput($sformatf("vec%0d_valid", n-2), 64'(link_valid), 64'd1);
                checkOutput($sformatf("vec%0d_lane0", n-2), 64'(link_data[31:0]), 64'(vecs[n-2].exp_l0));
                checkOutput($sformatf("vec%0d_lane1", n-2), 64'(link_data[63:32]), 64'(vecs[n-2].exp_l1));
            end
            reset = 1'b0;
            if (n < NV) applyStimulus(vecs[n].en, vecs[n].sel, vecs[n].data, vecs[n].dunf, 1'b1);
            else        applyStimulus(2'b00, 4'b0101, 64'h0, 1'b0, 1'b1);
            #1;
            if (n < NV) checkOutput($sformatf("vec%0d_dac_valid", n), 64'(dac_valid), 64'(vecs[n].exp_valid));
        end
        @(negedge clk);
        checkOutput("dunf_count_three", 64'(dunf_count), 64'd3);
        checkOutput("fmt_link_valid", 64'(f_link_valid), 64'd1);
        checkOutput("fmt_link_data", f_link_data, 64'h00800080_FCFF0000);

        // Ramp with a five-cycle stall in the middle
        reset = 1'b1;
        repeat (2) @(negedge clk);
        runRampCheck(30, 10, 5, "stall");

        // Reset asserted mid-stream while the link is stalled
        @(negedge clk);
        applyStimulus(2'b11, 4'b0011, ddata(16'h0, 16'h0, 16'h1111, 16'h2222), 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("midreset_dac_valid", 64'(dac_valid), 64'd0);
        @(negedge clk);
        checkOutput("midreset_link_valid", 64'(link_valid), 64'd0);
        checkOutput("midreset_link_data", link_data, 64'd0);
        runRampCheck(6, 100, 0, "post_reset");

        // PN7 on ch0, zero on ch1
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int n = 0; n < 4; n++) begin
            if (n > 0) @(negedge clk);
            if (n >= 2) begin
`ifdef JESD204_TPL_DAC_PN_EN
                if (n == 2) checkOutput("pn_first_sample", 64'({link_data[7:0], link_data[15:8]}), 64'h0000FE04);
                checkOutput($sformatf("pn_beat%0d_s0", n-2), 64'({link_data[7:0], link_data[15:8]}), 64'(pn_sample(2*(n-2))));
                checkOutput($sformatf("pn_beat%0d_s1", n-2), 64'({link_data[23:16], link_data[31:24]}), 64'(pn_sample(2*(n-2)+1)));
`else
                checkOutput($sformatf("pn_off_beat%0d_lane0", n-2), 64'(link_data[31:0]), 64'd0);
`endif
                checkOutput($sformatf("pn_beat%0d_lane1", n-2), 64'(link_data[63:32]), 64'd0);
            end
            reset = 1'b0;
            applyStimulus(2'b11, 4'b0110, ddata(16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555), 1'b0, 1'b1);
        end

        // Long run: ch0 ramp across its wrap, ch1 underflowing every beat
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        bad = 0;
        k   = 0;
        for (int n = 0; n < 70004; n++) begin
            if (n > 0) @(negedge clk);
            if (n == 1000) checkOutput("dunf_count_1000", 64'(dunf_count), 64'd1000);
            if (n >= 2) begin
                if (link_data[31:0] !== lane_word(16'(2*k), 16'(2*k+1))) bad++;
                if (link_data[63:32] !== 32'h0) bad++;
                if (k == 32767) checkOutput("ramp_pre_wrap", 64'(link_data[31:0]), 64'(lane_word(16'hFFFE, 16'hFFFF)));
                if (k == 32768) checkOutput("ramp_post_wrap", 64'(link_data[31:0]), 64'(lane_word(16'h0000, 16'h0001)));
                k++;
            end
            reset = 1'b0;
            applyStimulus(2'b10, 4'b0011, ddata(16'h0, 16'h0, 16'h3333, 16'h4444), 1'b1, 1'b1);
        end
        checkOutput("ramp_stream_errors", 64'(bad), 64'd0);
        checkOutput("dunf_count_saturated", 64'(dunf_count), 64'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
